lcd_controller: RTL and testbench
=================================

LCD_CONTROLLER -- requirements
Module: lcd_controller

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles RS/DATA are stable before EN rises; a value of 0 SHALL act as 1.
REQ-002 Parameter EN_HIGH_CYC, default 12: cycles EN is held high; a value of 0 SHALL act as 1.
REQ-003 Parameter HOLD_CYC, default 2: cycles after EN falls before execute wait; a value of 0 SHALL act as 1.
REQ-004 Parameter EXEC_CYC, default 2500: execute wait for normal commands and data writes; a value of 0 SHALL act as 1.
REQ-005 Parameter CLEAR_EXEC_CYC, default 82000: execute wait for clear/home commands; a value of 0 SHALL act as 1.
REQ-006 Parameter INIT_WAIT_CYC, default 750000: power-up wait; a value of 0 SHALL act as 1.
REQ-007 Port i_clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-008 Port i_reset, input, 1: synchronous, active-high reset.
REQ-009 Port i_wr_vld, input, 1: write request.
REQ-010 Port i_wr_data, input, 9: {rs, byte}; rs=0 is a command, rs=1 is display data.
REQ-011 Port o_wr_rdy, output, 1: the block can accept a write this cycle.
REQ-012 Port o_busy, output, 1: SHALL equal ~o_wr_rdy.
REQ-013 Ports o_lcd_data (8), o_lcd_rs (1), o_lcd_rw (1), o_lcd_en (1), o_lcd_on (1), o_lcd_blon (1), all outputs: HD44780 pins, all registered.

Function
REQ-014 FSM states SHALL be INIT_WAIT, INIT_CMD, IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-015 o_wr_rdy SHALL be 1 only in IDLE.
REQ-016 A write SHALL be accepted when i_wr_vld&&o_wr_rdy; i_wr_vld while not ready SHALL be ignored, with no buffering.
REQ-017 On accept at cycle N, i_wr_data SHALL be registered onto o_lcd_rs/o_lcd_data at N+1, and the FSM SHALL enter SETUP at N+1.
REQ-018 Each state SHALL last its parameter's cycle count: SETUP for SETUP_CYC, PULSE for EN_HIGH_CYC, HOLD for HOLD_CYC, then EXEC, then IDLE.
REQ-019 o_lcd_en SHALL be 1 only in PULSE.
REQ-020 EXEC SHALL use CLEAR_EXEC_CYC when rs=0 and byte[7:2]==0 with byte!=0 (0x01–0x03), and EXEC_CYC otherwise.
REQ-021 o_wr_rdy SHALL return high exactly SETUP+EN_HIGH+HOLD+EXEC cycles after N+1.
REQ-022 o_lcd_data/o_lcd_rs SHALL hold the last transferred value until the next transfer.
REQ-023 o_lcd_rw SHALL be constant 0; o_lcd_on and o_lcd_blon SHALL be constant 1 out of reset.
REQ-024 A single timing counter SHALL reload on every state entry and count down to 1; the state SHALL advance when the counter is 1.

Reset
REQ-025 On i_reset=1 at a clock edge: o_lcd_en=0, o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_on=1, o_lcd_blon=1, counters cleared, init index=0.
REQ-026 Reset SHALL take the state to INIT_WAIT with LCD_INIT_SEQ_EN defined, and to IDLE without it.
REQ-027 Reset asserted mid-operation, including during PULSE, SHALL abort: EN is low the next cycle, and the pending command is dropped.
REQ-028 Reset SHALL take priority over a simultaneous i_wr_vld.

Configuration
REQ-029 The macro LCD_INIT_SEQ_EN SHALL select the power-up sequence.
REQ-030 With LCD_INIT_SEQ_EN defined: INIT_WAIT lasts INIT_WAIT_CYC; INIT_CMD then issues 0x38, 0x0C, 0x01, 0x06 (rs=0), each through SETUP/PULSE/HOLD/EXEC per REQ-018/REQ-020; IDLE is entered after the fourth; o_wr_rdy=0 throughout.
REQ-031 Without LCD_INIT_SEQ_EN: INIT_WAIT, INIT_CMD and the init ROM are absent; o_wr_rdy=1 on the first cycle after reset.

Verification
REQ-032 All scenarios SHALL use parameters 2/3/1/5/20/10.
REQ-033 No macro, reset released, i_wr_vld=1, i_wr_data=0x141 -> rs=1 and data=0x41 at N+1; EN high for cycles N+3..N+5; o_wr_rdy high at N+12.
REQ-034 Command 0x001 -> same timing as REQ-033 except EXEC is 20 cycles; o_wr_rdy high at N+27.
REQ-035 i_wr_vld pulsed with 0x155 while busy -> ignored; data stays 0x41; no extra EN pulse.
REQ-036 Reset asserted on the second cycle of EN -> EN=0 the next cycle; outputs at reset values; o_wr_rdy=1 one cycle after reset releases (no macro).
REQ-037 LCD_INIT_SEQ_EN defined -> 10 idle cycles, then EN pulses with data 0x38, 0x0C, 0x01, 0x06 at the REQ-030 spacing; o_wr_rdy rises only after the 0x06 EXEC; back-to-back host writes then each produce exactly one EN pulse.

Source files
------------

// File: rtl/lcd_controller.sv
// ============================================================================
//  Module      : lcd_controller
//  Description : HD44780 character-LCD write sequencer (setup/EN/hold/execute).
//                Define LCD_INIT_SEQ_EN to add the power-up init sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_controller #(
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EN_HIGH_CYC    = 12,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned EXEC_CYC       = 2500,
    parameter int unsigned CLEAR_EXEC_CYC = 82000,
    parameter int unsigned INIT_WAIT_CYC  = 750000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_vld,
    input  logic [8:0] i_wr_data,
    output logic       o_wr_rdy,
    output logic       o_busy,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on,
    output logic       o_lcd_blon
);

    // A zero-length phase is treated as one cycle.
    localparam int unsigned c_setup_cyc = (SETUP_CYC      == 0) ? 1 : SETUP_CYC;
    localparam int unsigned c_en_cyc    = (EN_HIGH_CYC    == 0) ? 1 : EN_HIGH_CYC;
    localparam int unsigned c_hold_cyc  = (HOLD_CYC       == 0) ? 1 : HOLD_CYC;
    localparam int unsigned c_exec_cyc  = (EXEC_CYC       == 0) ? 1 : EXEC_CYC;
    localparam int unsigned c_clear_cyc = (CLEAR_EXEC_CYC == 0) ? 1 : CLEAR_EXEC_CYC;
    localparam int unsigned c_init_cyc  = (INIT_WAIT_CYC  == 0) ? 1 : INIT_WAIT_CYC;

    localparam int unsigned c_max_0   = (c_setup_cyc > c_en_cyc)   ? c_setup_cyc : c_en_cyc;
    localparam int unsigned c_max_1   = (c_hold_cyc  > c_exec_cyc) ? c_hold_cyc  : c_exec_cyc;
    localparam int unsigned c_max_2   = (c_clear_cyc > c_init_cyc) ? c_clear_cyc : c_init_cyc;
    localparam int unsigned c_max_3   = (c_max_0 > c_max_1) ? c_max_0 : c_max_1;
    localparam int unsigned c_max_cyc = (c_max_3 > c_max_2) ? c_max_3 : c_max_2;
    localparam int          c_cnt_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_cnt_w-1:0] c_ld_setup = c_cnt_w'(c_setup_cyc);
    localparam logic [c_cnt_w-1:0] c_ld_en    = c_cnt_w'(c_en_cyc);
    localparam logic [c_cnt_w-1:0] c_ld_hold  = c_cnt_w'(c_hold_cyc);
    localparam logic [c_cnt_w-1:0] c_ld_exec  = c_cnt_w'(c_exec_cyc);
    localparam logic [c_cnt_w-1:0] c_ld_clear = c_cnt_w'(c_clear_cyc);
    localparam logic [c_cnt_w-1:0] c_ld_one   = c_cnt_w'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        PULSE     = 3'd2,
        HOLD      = 3'd3,
        EXEC      = 3'd4
`ifdef LCD_INIT_SEQ_EN
        ,
        INIT_WAIT = 3'd5,
        INIT_CMD  = 3'd6
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [c_cnt_w-1:0]   cnt_q,   cnt_d;
    logic [7:0]           data_q,  data_d;
    logic                 rs_q,    rs_d;
    logic                 en_q,    en_d;
    logic                 rdy_q,   rdy_d;

    logic                 w_accept;
    logic                 w_done;
    logic                 w_clear_cmd;
    logic [c_cnt_w-1:0]   w_exec_ld;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           w_rom_byte;
    logic [c_cnt_w-1:0]   w_wait_left;

    always_comb begin
        case (idx_q[1:0])
            2'd0:    w_rom_byte = 8'h38;
            2'd1:    w_rom_byte = 8'h0C;
            2'd2:    w_rom_byte = 8'h01;
            default: w_rom_byte = 8'h06;
        endcase
    end

    // The counter is cleared by reset, so a zero here means a fresh power-up wait.
    assign w_wait_left = (cnt_q == '0) ? c_cnt_w'(c_init_cyc) : cnt_q;
`endif

    assign w_accept    = i_wr_vld & rdy_q;
    assign w_done      = (cnt_q == c_ld_one);
    assign w_clear_cmd = ~rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign w_exec_ld   = w_clear_cmd ? c_ld_clear : c_ld_exec;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
`ifdef LCD_INIT_SEQ_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    data_d  = i_wr_data[7:0];
                    rs_d    = i_wr_data[8];
                    state_d = SETUP;
                    cnt_d   = c_ld_setup;
                end
            end
            SETUP: begin
                if (w_done) begin
                    state_d = PULSE;
                    cnt_d   = c_ld_en;
                end else begin
                    cnt_d   = cnt_q - c_ld_one;
                end
            end
            PULSE: begin
                if (w_done) begin
                    state_d = HOLD;
                    cnt_d   = c_ld_hold;
                end else begin
                    cnt_d   = cnt_q - c_ld_one;
                end
            end
            HOLD: begin
                if (w_done) begin
                    state_d = EXEC;
                    cnt_d   = w_exec_ld;
                end else begin
                    cnt_d   = cnt_q - c_ld_one;
                end
            end
            EXEC: begin
                if (w_done) begin
`ifdef LCD_INIT_SEQ_EN
                    state_d = (idx_q < 3'd4) ? INIT_CMD : IDLE;
`else
                    state_d = IDLE;
`endif
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - c_ld_one;
                end
            end
`ifdef LCD_INIT_SEQ_EN
            INIT_WAIT: begin
                if (w_wait_left == c_ld_one) begin
                    state_d = INIT_CMD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = w_wait_left - c_ld_one;
                end
            end
            INIT_CMD: begin
                data_d  = w_rom_byte;
                rs_d    = 1'b0;
                idx_d   = idx_q + 3'd1;
                state_d = SETUP;
                cnt_d   = c_ld_setup;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign en_d  = (state_d == PULSE);
    assign rdy_d = (state_d == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
`ifdef LCD_INIT_SEQ_EN
            state_q <= INIT_WAIT;
            rdy_q   <= 1'b0;
            idx_q   <= 3'd0;
`else
            state_q <= IDLE;
            rdy_q   <= 1'b1;
`endif
            cnt_q   <= '0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
`ifdef LCD_INIT_SEQ_EN
            idx_q   <= idx_d;
`endif
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            en_q    <= en_d;
        end
    end

    assign o_wr_rdy   = rdy_q;
    assign o_busy     = ~rdy_q;
    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_en   = en_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_on   = 1'b1;
    assign o_lcd_blon = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_lcd_controller.sv
// ============================================================================
//  Module      : tb_lcd_controller
//  Description : Self-checking bench for lcd_controller against a
//                transaction-level timing model (honours LCD_INIT_SEQ_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_controller;

    localparam int S  = 2;
    localparam int E  = 3;
    localparam int H  = 1;
    localparam int X  = 5;
    localparam int C  = 20;
    localparam int IW = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld;
    logic [8:0] wdata;
    logic       o_wr_rdy, o_busy, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_blon;
    logic [7:0] o_lcd_data;

    always #5 clk = ~clk;

    lcd_controller #(
        .SETUP_CYC      (S),
        .EN_HIGH_CYC    (E),
        .HOLD_CYC       (H),
        .EXEC_CYC       (X),
        .CLEAR_EXEC_CYC (C),
        .INIT_WAIT_CYC  (IW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wr_vld   (vld),
        .i_wr_data  (wdata),
        .o_wr_rdy   (o_wr_rdy),
        .o_busy     (o_busy),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_blon (o_lcd_blon)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction model: a transfer is a phase index k running 0..dur-1 after acceptance.
    int         wait_rem = 0;
    bit         issue    = 0;
    bit         active   = 0;
    int         k        = 0;
    int         dur      = 0;
    logic [7:0] m_data   = 8'h00;
    logic       m_rs     = 1'b0;
    logic [7:0] q[$];

    int   en_rises = 0;
    logic prev_en  = 1'b0;

    function automatic int exec_len(logic rs, logic [7:0] b);
        return (!rs && b >= 8'd1 && b <= 8'd3) ? C : X;
    endfunction

    function automatic void start_xfer(logic rs, logic [7:0] b);
        m_rs   = rs;
        m_data = b;
        active = 1'b1;
        k      = 0;
        dur    = S + E + H + exec_len(rs, b);
    endfunction

    function automatic bit m_rdy();
        return !active && !issue && (wait_rem == 0) && (q.size() == 0);
    endfunction

    function automatic bit m_en();
        return active && (k >= S) && (k < S + E);
    endfunction

    function automatic void model_update();
        if (rst) begin
            active = 1'b0;
            issue  = 1'b0;
            k      = 0;
            m_data = 8'h00;
            m_rs   = 1'b0;
`ifdef LCD_INIT_SEQ_EN
            wait_rem = IW;
            q        = '{8'h38, 8'h0C, 8'h01, 8'h06};
`else
            wait_rem = 0;
            q.delete();
`endif
        end else if (wait_rem > 0) begin
            wait_rem--;
            if (wait_rem == 0) issue = 1'b1;
        end else if (issue) begin
            issue = 1'b0;
            start_xfer(1'b0, q.pop_front());
        end else if (active) begin
            k++;
            if (k == dur) begin
                active = 1'b0;
                if (q.size() != 0) issue = 1'b1;
            end
        end else if (vld) begin
            start_xfer(wdata[8], wdata[7:0]);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        if (o_lcd_en === 1'b1 && prev_en !== 1'b1) en_rises++;
        prev_en = o_lcd_en;
        check("wr_rdy",   {31'd0, o_wr_rdy},   {31'd0, m_rdy()});
        check("busy",     {31'd0, o_busy},     {31'd0, !m_rdy()});
        check("lcd_en",   {31'd0, o_lcd_en},   {31'd0, m_en()});
        check("lcd_data", {24'd0, o_lcd_data}, {24'd0, m_data});
        check("lcd_rs",   {31'd0, o_lcd_rs},   {31'd0, m_rs});
        check("lcd_rw",   {31'd0, o_lcd_rw},   32'd0);
        check("lcd_on",   {31'd0, o_lcd_on},   32'd1);
        check("lcd_blon", {31'd0, o_lcd_blon}, 32'd1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (o_wr_rdy !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check("ready_timeout", {31'd0, o_wr_rdy}, 32'd1);
    endtask

    task automatic send(input logic [8:0] d);
        vld   = 1'b1;
        wdata = d;
        tick();
        vld   = 1'b0;
    endtask

    initial begin
        int n;
        logic [8:0] bnd[5];
        bnd = '{9'h000, 9'h003, 9'h004, 9'h101, 9'h102};
        rst   = 1'b1;
        vld   = 1'b0;
        wdata = 9'h000;

        // Reset, with a write request held high to show reset wins.
        vld = 1'b1; wdata = 9'h1AA;
        repeat (3) tick();
        vld = 1'b0;
        rst = 1'b0;
        wait_ready(n);
        repeat (2) tick();

        // Data write 0x141: ready again 12 cycles after acceptance.
        en_rises = 0;
        send(9'h141);
        check("data_at_n1", {23'd0, o_lcd_rs, o_lcd_data}, 32'h141);
        wait_ready(n);
        check("latency_data", n + 1, 1 + S + E + H + X);
        check("en_pulses_data", en_rises, 1);

        // Clear-display command: long execute wait.
        send(9'h001);
        wait_ready(n);
        check("latency_clear", n + 1, 1 + S + E + H + C);

        // Write ignored while busy.
        send(9'h141);
        en_rises = 0;
        repeat (2) tick();
        vld = 1'b1; wdata = 9'h155;
        tick();
        vld = 1'b0;
        wait_ready(n);
        check("busy_ignored_data", {24'd0, o_lcd_data}, 32'h41);
        check("busy_ignored_pulses", en_rises, 1);

        // Reset during the second EN-high cycle aborts the transfer.
        send(9'h148);
        n = 0;
        while (o_lcd_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("en_seen", {31'd0, o_lcd_en}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check("abort_en", {31'd0, o_lcd_en}, 32'd0);
        check("abort_data", {23'd0, o_lcd_rs, o_lcd_data}, 32'd0);
        rst = 1'b0;
        tick();
        wait_ready(n);

        // Execute-time decode boundaries.
        foreach (bnd[i]) begin
            send(bnd[i]);
            wait_ready(n);
            check("latency_boundary", n + 1, 1 + S + E + H + exec_len(bnd[i][8], bnd[i][7:0]));
        end

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 700; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            vld = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                wdata = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 4))};
            else
                wdata = 9'($urandom_range(0, 511));
            tick();
        end
        rst = 1'b0;
        vld = 1'b0;
        wait_ready(n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
